abs_volt_quantizer: RTL and testbench

//  Digital consumer placed downstream of an analog voltage contribution such as V(out) <+ abs(value).
//  It samples a real-valued node voltage, carried as IEEE-754 bits, on a start request.

---
 rtl/abs_volt_quantizer.sv | 114 +++++++++++
 tb/tb_abs_volt_quantizer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/abs_volt_quantizer.sv
// abs_volt_quantizer: samples an IEEE-754 double voltage and returns a rounded, saturated signed code after a fixed delay.
// LSB must be a power of two, so the scaling is an exponent offset and no multiplier or divider is needed.
module abs_volt_quantizer #(
  parameter int  WIDTH       = 12,
  parameter real LSB         = 0.0009765625,
  parameter int  CONV_CYCLES = 4,
  parameter int  CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      vin_bits,
  output logic             busy,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [WIDTH-1:0] code,
  output logic [WIDTH-1:0] mag,
  output logic             sign,
  output logic             sat,
  output logic [CNT_W-1:0] sat_count
);
  function automatic int lsb_shift(input real l);
    real x;
    int k;
    x = l;
    k = 0;
    for (int i = 0; i < 64; i++) begin
      if (x < 1.0) begin
        x = x * 2.0;
        k++;
      end else if (x > 1.0) begin
        x = x / 2.0;
        k--;
      end
    end
    return k;
  endfunction
  localparam int CW = CONV_CYCLES > 1 ? $clog2(CONV_CYCLES) : 1;
  localparam logic signed [12:0] SW = 13'(WIDTH);
  localparam logic [WIDTH:0] HALF = (WIDTH+1)'(1) << (WIDTH-1);
  localparam logic [WIDTH-1:0] MAXC = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINC = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [63:0] vq;
  logic neg, is_sp, nan, big, tiny, ovf, clamp, c_sat;
  logic signed [12:0] sh;
  logic [12:0] sa;
  logic [52:0] sig;
  logic [WIDTH:0] x2, mag_r;
  logic [WIDTH-1:0] c_code, c_mag;
  // sh is the binary weight of the hidden bit in code units; x2 keeps one fraction bit for rounding
  assign neg   = vq[63];
  assign is_sp = &vq[62:52];
  assign nan   = is_sp & |vq[51:0];
  assign sig   = {|vq[62:52], vq[51:0]};
  assign sh    = $signed({2'b0, vq[62:52]}) - 13'sd1023 + 13'(lsb_shift(LSB));
  assign sa    = 13'd51 - sh;
  assign x2    = (WIDTH+1)'(sig >> sa);
  assign mag_r = (WIDTH+1)'(({1'b0, x2} + (WIDTH+2)'(1)) >> 1);
  assign big   = sh >= SW;
  assign tiny  = sh < -13'sd1;
  assign ovf   = neg ? mag_r > HALF : mag_r >= HALF;
  assign clamp = (is_sp & ~nan) | (~is_sp & (big | (~tiny & ovf)));
  assign c_sat = is_sp | clamp;
  assign c_code = nan ? '0 : clamp ? (neg ? MINC : MAXC) : tiny ? '0 :
                  neg ? WIDTH'(-mag_r[WIDTH-1:0]) : mag_r[WIDTH-1:0];
  assign c_mag = c_code[WIDTH-1] ? WIDTH'(-c_code) : c_code;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      vq         <= '0;
      busy       <= 1'b0;
      code_valid <= 1'b0;
      code       <= '0;
      mag        <= '0;
      sign       <= 1'b0;
      sat        <= 1'b0;
      sat_count  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          vq    <= vin_bits;
          cnt   <= CW'(CONV_CYCLES - 1);
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: if (cnt == '0) begin
          code       <= c_code;
          mag        <= c_mag;
          sign       <= c_code[WIDTH-1];
          sat        <= c_sat;
          sat_count  <= sat_count + CNT_W'(c_sat & ~&sat_count);
          code_valid <= 1'b1;
          state      <= DONE;
        end else cnt <= cnt - CW'(1);
        DONE: if (code_ready) begin
          code_valid <= 1'b0;
          if (start) begin
            vq    <= vin_bits;
            cnt   <= CW'(CONV_CYCLES - 1);
            state <= CONV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_abs_volt_quantizer.sv
// tb_abs_volt_quantizer: directed vectors with hand-computed codes for WIDTH=12, LSB=1/1024, CONV_CYCLES=4.
module tb_abs_volt_quantizer;
  logic clk = 0, rst_n = 0, start = 0, code_ready = 0;
  logic [63:0] vin_bits = '0;
  logic busy, code_valid, sign, sat;
  logic [11:0] code, mag;
  logic [7:0] sat_count;
  int checks = 0, failures = 0;
  abs_volt_quantizer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vin_bits(vin_bits), .busy(busy),
    .code_valid(code_valid), .code_ready(code_ready), .code(code), .mag(mag),
    .sign(sign), .sat(sat), .sat_count(sat_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic conv(input logic [63:0] b, output int lat);
    @(negedge clk);
    vin_bits = b;
    start = 1;
    @(negedge clk);
    start = 0;
    lat = 0;
    while (!code_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run(input string tag, input logic [63:0] b, input logic [11:0] ec,
                     input logic [11:0] em, input logic es, input logic esat);
    int lat;
    conv(b, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_code"}, 64'(code), 64'(ec));
    chk({tag, "_mag"}, 64'(mag), 64'(em));
    chk({tag, "_sign"}, 64'(sign), 64'(es));
    chk({tag, "_sat"}, 64'(sat), 64'(esat));
    code_ready = 1;
    @(negedge clk);
    code_ready = 0;
    chk({tag, "_vdrop"}, 64'(code_valid), 64'd0);
  endtask
  initial begin
    int lat, busy_n, bad;
    #12;
    chk("rst_valid", 64'(code_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_code", 64'(code), 64'd0);
    chk("rst_cnt", 64'(sat_count), 64'd0);
    @(negedge clk);
    rst_n = 1;
    // 1.0 V with the consumer always ready: one-cycle valid, busy spans five cycles
    @(negedge clk);
    vin_bits = $realtobits(1.0);
    start = 1;
    code_ready = 1;
    @(negedge clk);
    start = 0;
    busy_n = busy ? 1 : 0;
    lat = 99;
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (code_valid && lat == 99) lat = i;
    end
    code_ready = 0;
    chk("t1_lat", 64'(lat), 64'd4);
    chk("t1_code", 64'(code), 64'd1024);
    chk("t1_mag", 64'(mag), 64'd1024);
    chk("t1_busy", 64'(busy_n), 64'd5);
    run("neg1", $realtobits(-1.0), 12'hC00, 12'd1024, 1'b1, 1'b0);
    run("pos5", $realtobits(5.0), 12'd2047, 12'd2047, 1'b0, 1'b1);
    chk("cnt1", 64'(sat_count), 64'd1);
    run("neg5", $realtobits(-5.0), 12'h800, 12'd2048, 1'b1, 1'b1);
    chk("cnt2", 64'(sat_count), 64'd2);
    run("nan", 64'h7FF8000000000000, 12'd0, 12'd0, 1'b0, 1'b1);
    chk("cnt3", 64'(sat_count), 64'd3);
    run("rhalf", $realtobits(1.5 / 1024.0), 12'd2, 12'd2, 1'b0, 1'b0);
    run("rnhalf", $realtobits(-1.5 / 1024.0), 12'hFFE, 12'd2, 1'b1, 1'b0);
    run("r149", $realtobits(1.49 / 1024.0), 12'd1, 12'd1, 1'b0, 1'b0);
    run("negz", 64'h8000000000000000, 12'd0, 12'd0, 1'b0, 1'b0);
    chk("cnt_hold", 64'(sat_count), 64'd3);
    // backpressure: result held while start pulses are ignored
    conv($realtobits(0.25), lat);
    chk("bp_lat", 64'(lat), 64'd4);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      vin_bits = $realtobits(3.0 + i);
      start = (i % 2) == 0;
      @(negedge clk);
      if (!code_valid || code !== 12'd256 || mag !== 12'd256 || sat !== 1'b0) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    vin_bits = $realtobits(0.5);
    start = 1;
    code_ready = 1;
    @(negedge clk);
    start = 0;
    code_ready = 0;
    chk("b2b_drop", 64'(code_valid), 64'd0);
    chk("b2b_hold", 64'(code), 64'd256);
    lat = 0;
    while (!code_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat", 64'(lat), 64'd4);
    chk("b2b_code", 64'(code), 64'd512);
    code_ready = 1;
    @(negedge clk);
    code_ready = 0;
    // asynchronous reset mid-conversion
    @(negedge clk);
    vin_bits = $realtobits(1.0);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_valid", 64'(code_valid), 64'd0);
    chk("ar_code", 64'(code), 64'd0);
    chk("ar_mag", 64'(mag), 64'd0);
    chk("ar_sat", 64'(sat), 64'd0);
    chk("ar_cnt", 64'(sat_count), 64'd0);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (code_valid || busy) bad++;
    end
    chk("ar_novalid", 64'(bad), 64'd0);
    run("post", $realtobits(0.5), 12'd512, 12'd512, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
